// File: rtl/alu_stage.sv
// alu_stage: two-register execute stage wrapped around a combinational ALU.
//
// Stage 1 registers the decoded op, both operands and the destination index.
// It drives the op and operands straight to the external ALU. Stage 2 captures
// the ALU result and the destination index and presents them to writeback.
// Each stage holds a single entry and there is no skid buffer, so o_ready
// depends combinationally on i_ready.
//
// Ports
//   i_clock                      clock; all state changes on the rising edge
//   i_reset                      asynchronous reset, active low
//   i_flush                      synchronous kill of every in-flight entry
//   i_valid / o_ready            upstream handshake
//   i_op, i_data0, i_data1, i_rd upstream op, operands and destination index
//   o_alu_op, o_alu_data0/1      stage-1 registers that feed the ALU
//   i_alu_data                   combinational result returned by the ALU
//   o_valid / i_ready            downstream handshake
//   o_data, o_rd                 stage-2 result and destination index
module alu_stage #(
  parameter int DATA_WIDTH = 16,
  parameter int RD_WIDTH   = 5
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_flush,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [3:0]            i_op,
  input  logic [DATA_WIDTH-1:0] i_data0,
  input  logic [DATA_WIDTH-1:0] i_data1,
  input  logic [RD_WIDTH-1:0]   i_rd,
  output logic [3:0]            o_alu_op,
  output logic [DATA_WIDTH-1:0] o_alu_data0,
  output logic [DATA_WIDTH-1:0] o_alu_data1,
  input  logic [DATA_WIDTH-1:0] i_alu_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [RD_WIDTH-1:0]   o_rd
);

  logic                  vld_p1;
  logic [3:0]            op_p1;
  logic [DATA_WIDTH-1:0] data0_p1;
  logic [DATA_WIDTH-1:0] data1_p1;
  logic [RD_WIDTH-1:0]   rd_p1;

  logic                  vld_p2;
  logic [DATA_WIDTH-1:0] data_p2;
  logic [RD_WIDTH-1:0]   rd_p2;

  logic accept;
  logic s2_free;
  logic s1_move;

  // The handshake chain runs from i_ready back to o_ready. The stage can take
  // a new input when stage 1 is empty or when its entry moves on this cycle.
  // A flush does not gate o_ready. A flushed input is dropped later, when the
  // registers are written.
  always_comb begin
    s2_free = ~vld_p2 | i_ready;
    s1_move = vld_p1 & s2_free;
    o_ready = ~vld_p1 | s1_move;
    accept  = i_valid & o_ready;
  end

  // ---- Stage 1: op/operand/rd registers driving the ALU ----
  // The data registers keep their value after the entry drains. They load only
  // on a real accept, so a flushed input never reaches the ALU.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      vld_p1   <= 1'b0;
      op_p1    <= '0;
      data0_p1 <= '0;
      data1_p1 <= '0;
      rd_p1    <= '0;
    end else begin
      if (i_flush)
        vld_p1 <= 1'b0;
      else if (accept)
        vld_p1 <= 1'b1;
      else if (s1_move)
        vld_p1 <= 1'b0;

      if (accept && !i_flush) begin
        op_p1    <= i_op;
        data0_p1 <= i_data0;
        data1_p1 <= i_data1;
        rd_p1    <= i_rd;
      end
    end
  end

  // ---- Stage 2: ALU result capture toward writeback ----
  // The result loads only when the stage-1 entry moves. o_data and o_rd
  // therefore stay stable while writeback stalls.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      vld_p2  <= 1'b0;
      data_p2 <= '0;
      rd_p2   <= '0;
    end else begin
      if (i_flush)
        vld_p2 <= 1'b0;
      else if (s1_move)
        vld_p2 <= 1'b1;
      else if (vld_p2 && i_ready)
        vld_p2 <= 1'b0;

      if (s1_move && !i_flush) begin
        data_p2 <= i_alu_data;
        rd_p2   <= rd_p1;
      end
    end
  end

  assign o_alu_op    = op_p1;
  assign o_alu_data0 = data0_p1;
  assign o_alu_data1 = data1_p1;
  assign o_valid     = vld_p2;
  assign o_data      = data_p2;
  assign o_rd        = rd_p2;

endmodule

// File: tb/tb_alu_stage.sv
// Testbench for alu_stage. A small reference ALU closes the loop, and a
// queue-based scoreboard checks every result that writeback accepts.
module tb_alu_stage;

  localparam int DW = 16;
  localparam int RW = 5;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;

  logic          i_clock = 1'b0;
  logic          i_reset = 1'b0;
  logic          i_flush = 1'b0;
  logic          i_valid = 1'b0;
  logic          o_ready;
  logic [3:0]    i_op    = '0;
  logic [DW-1:0] i_data0 = '0;
  logic [DW-1:0] i_data1 = '0;
  logic [RW-1:0] i_rd    = '0;
  logic [3:0]    o_alu_op;
  logic [DW-1:0] o_alu_data0;
  logic [DW-1:0] o_alu_data1;
  logic [DW-1:0] i_alu_data;
  logic          o_valid;
  logic          i_ready = 1'b1;
  logic [DW-1:0] o_data;
  logic [RW-1:0] o_rd;

  alu_stage #(.DATA_WIDTH(DW), .RD_WIDTH(RW)) dut (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_flush    (i_flush),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_op       (i_op),
    .i_data0    (i_data0),
    .i_data1    (i_data1),
    .i_rd       (i_rd),
    .o_alu_op   (o_alu_op),
    .o_alu_data0(o_alu_data0),
    .o_alu_data1(o_alu_data1),
    .i_alu_data (i_alu_data),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_data     (o_data),
    .o_rd       (o_rd)
  );

  always #5 i_clock = ~i_clock;

  always_comb begin
    i_alu_data = '0;
    case (o_alu_op)
      OP_ADD:  i_alu_data = o_alu_data0 + o_alu_data1;
      OP_SUB:  i_alu_data = o_alu_data0 - o_alu_data1;
      OP_AND:  i_alu_data = o_alu_data0 & o_alu_data1;
      OP_OR:   i_alu_data = o_alu_data0 | o_alu_data1;
      OP_XOR:  i_alu_data = o_alu_data0 ^ o_alu_data1;
      default: i_alu_data = '0;
    endcase
  end

  typedef struct packed {
    logic [DW-1:0] data;
    logic [RW-1:0] rd;
  } exp_t;

  exp_t q[$];
  int   pop_cyc[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  always @(posedge i_clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Scoreboard monitor: compares each accepted result with the queue head.
  always @(negedge i_clock) begin
    if (i_reset && o_valid && i_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_result", {11'd0, o_rd, o_data}, 32'hDEAD_0000);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("result_data", {16'd0, o_data}, {16'd0, e.data});
        chk("result_rd", {27'd0, o_rd}, {27'd0, e.rd});
        pop_cyc.push_back(cyc);
      end
    end
  end

  // Drives one op. On return the bench is at the accept negedge and i_valid is
  // still high, so back-to-back sends form a continuous stream.
  task automatic send(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [RW-1:0] rd, input logic [DW-1:0] ed, input logic rdy,
                      output int waits);
    bit done;
    exp_t e;
    done  = 0;
    waits = 0;
    @(posedge i_clock); #1;
    i_valid = 1'b1; i_op = op; i_data0 = a; i_data1 = b; i_rd = rd; i_ready = rdy;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge i_clock);
      if (o_ready) begin
        e.data = ed; e.rd = rd;
        q.push_back(e);
        done = 1;
      end else begin
        waits++;
      end
    end
    if (!done) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle();
    @(posedge i_clock); #1;
    i_valid = 1'b0;
  endtask

  // Called at the accept negedge. Checks that the single result shows up two
  // cycles later and stays valid for exactly one cycle.
  task automatic lat_check(input string name);
    idle();
    @(negedge i_clock); chk({name, "_n1"}, {31'd0, o_valid}, 32'd0);
    @(negedge i_clock); chk({name, "_n2"}, {31'd0, o_valid}, 32'd1);
    @(negedge i_clock); chk({name, "_n3"}, {31'd0, o_valid}, 32'd0);
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 100 && q.size() != 0; k++) @(negedge i_clock);
    chk(name, q.size(), 32'd0);
  endtask

  logic [3:0]    t2_op [8];
  logic [DW-1:0] t2_a  [8];
  logic [DW-1:0] t2_b  [8];
  logic [DW-1:0] t2_r  [8];

  initial begin
    int w;
    int stalls;

    t2_op[0] = OP_ADD; t2_a[0] = 16'h0001; t2_b[0] = 16'h0001; t2_r[0] = 16'h0002;
    t2_op[1] = OP_SUB; t2_a[1] = 16'h000A; t2_b[1] = 16'h0003; t2_r[1] = 16'h0007;
    t2_op[2] = OP_AND; t2_a[2] = 16'hF0F0; t2_b[2] = 16'h0FF0; t2_r[2] = 16'h00F0;
    t2_op[3] = OP_OR;  t2_a[3] = 16'h1200; t2_b[3] = 16'h0034; t2_r[3] = 16'h1234;
    t2_op[4] = OP_XOR; t2_a[4] = 16'hAAAA; t2_b[4] = 16'h5555; t2_r[4] = 16'hFFFF;
    t2_op[5] = OP_ADD; t2_a[5] = 16'hFFFF; t2_b[5] = 16'h0001; t2_r[5] = 16'h0000;
    t2_op[6] = OP_SUB; t2_a[6] = 16'h0000; t2_b[6] = 16'h0001; t2_r[6] = 16'hFFFF;
    t2_op[7] = OP_ADD; t2_a[7] = 16'h8000; t2_b[7] = 16'h8000; t2_r[7] = 16'h0000;

    // Reset state
    #3;
    chk("rst_o_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_o_ready", {31'd0, o_ready}, 32'd1);
    chk("rst_o_data", {16'd0, o_data}, 32'd0);
    chk("rst_o_rd", {27'd0, o_rd}, 32'd0);
    chk("rst_o_alu_op", {28'd0, o_alu_op}, 32'd0);
    @(posedge i_clock); #1;
    i_reset = 1'b1;

    // 1: single ADD, latency and single-cycle valid
    send(OP_ADD, 16'd3, 16'd4, 5'd5, 16'd7, 1'b1, w);
    lat_check("t1_lat");
    drain("t1_drain");

    // 2: eight back-to-back ops, including rd=0 and wrap-around results
    pop_cyc.delete();
    stalls = 0;
    for (int i = 0; i < 8; i++) begin
      send(t2_op[i], t2_a[i], t2_b[i], i[RW-1:0], t2_r[i], 1'b1, w);
      stalls += w;
    end
    idle();
    drain("t2_drain");
    chk("t2_no_stall", stalls, 32'd0);
    chk("t2_count", pop_cyc.size(), 32'd8);
    for (int i = 1; i < pop_cyc.size(); i++)
      chk("t2_consecutive", pop_cyc[i] - pop_cyc[i-1], 32'd1);

    // 3: downstream stall fills both stages, then releases in order
    send(OP_ADD, 16'd5, 16'd6, 5'd1, 16'h000B, 1'b0, w);
    send(OP_OR, 16'h0F00, 16'h00F0, 5'd2, 16'h0FF0, 1'b0, w);
    @(posedge i_clock); #1;
    i_op = OP_XOR; i_data0 = 16'h1234; i_data1 = 16'h1234; i_rd = 5'd3;
    repeat (3) begin
      @(negedge i_clock);
      chk("t3_full_ready", {31'd0, o_ready}, 32'd0);
      chk("t3_hold_valid", {31'd0, o_valid}, 32'd1);
      chk("t3_hold_data", {16'd0, o_data}, 32'h000B);
      chk("t3_hold_rd", {27'd0, o_rd}, 32'd1);
    end
    send(OP_XOR, 16'h1234, 16'h1234, 5'd3, 16'h0000, 1'b1, w);
    idle();
    drain("t3_drain");

    // 4: flush with two in flight; the S2 handshake in the flush cycle completes
    send(OP_ADD, 16'd1, 16'd2, 5'd4, 16'd3, 1'b0, w);
    send(OP_ADD, 16'd2, 16'd2, 5'd6, 16'd4, 1'b0, w);
    @(posedge i_clock); #1;
    i_op = OP_ADD; i_data0 = 16'd9; i_data1 = 16'd9; i_rd = 5'd8;
    i_flush = 1'b1; i_ready = 1'b1;
    @(posedge i_clock); #1;
    i_flush = 1'b0; i_valid = 1'b0;
    chk("t4_d1_popped", q.size(), 32'd1);
    q.delete();
    chk("t4_flush_valid", {31'd0, o_valid}, 32'd0);
    chk("t4_flush_ready", {31'd0, o_ready}, 32'd1);
    repeat (4) begin
      @(negedge i_clock);
      chk("t4_no_emerge", {31'd0, o_valid}, 32'd0);
    end
    send(OP_SUB, 16'd9, 16'd4, 5'd7, 16'd5, 1'b1, w);
    lat_check("t4_lat");
    drain("t4_drain");

    // 5: asynchronous reset between edges with entries in flight
    send(OP_ADD, 16'h0100, 16'h0023, 5'd9, 16'h0123, 1'b1, w);
    send(OP_AND, 16'hFFFF, 16'h1234, 5'd10, 16'h1234, 1'b1, w);
    @(posedge i_clock); #1;
    i_valid = 1'b0;
    chk("t5_pre_valid", {31'd0, o_valid}, 32'd1);
    #2;
    i_reset = 1'b0;
    q.delete();
    #1;
    chk("t5_rst_valid", {31'd0, o_valid}, 32'd0);
    chk("t5_rst_ready", {31'd0, o_ready}, 32'd1);
    chk("t5_rst_data", {16'd0, o_data}, 32'd0);
    chk("t5_rst_rd", {27'd0, o_rd}, 32'd0);
    chk("t5_rst_alu_a", {16'd0, o_alu_data0}, 32'd0);
    repeat (2) @(posedge i_clock);
    #1;
    i_reset = 1'b1;

    // 6: XOR through the reference ALU after reset release
    send(OP_XOR, 16'hFFFF, 16'h00FF, 5'd12, 16'hFF00, 1'b1, w);
    lat_check("t6_lat");
    drain("t6_drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
